// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and helpers for the modulo-N counter
//
// Purpose : next-state operation encoding, binary-to-Gray conversion and the
//           elaboration-time legality check on the WIDTH/MOD parameter pair.
// Ports   : none (package).
package cnt_pkg;

  // Widest counter the 32-bit helper functions can represent safely.
  localparam int MAX_WIDTH = 30;

  // Operation selected for the next edge, after priority resolution.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_REJECT,
    OP_UP,
    OP_DN
  } cnt_op_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Legal when 2 <= modv <= 2**width; the width bound keeps the shift in range.
  function automatic bit mod_is_legal(input int width, input int modv);
    if (width < 1 || width > MAX_WIDTH) return 1'b0;
    return (modv >= 2) && (longint'(modv) <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/mod_n_cnt_if.sv
// rtl/mod_n_cnt_if.sv - control and status bundle of the modulo-N counter
//
// Purpose : groups the counter controls and outputs.
// Signals : en, up_dn, clr, load, load_val  (master -> slave)
//           cnt, cnt_gray, tc, wrap, load_err (slave -> master)
interface mod_n_cnt_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_gray;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  cnt, cnt_gray, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output cnt, cnt_gray, tc, wrap, load_err
  );
endinterface

// File: rtl/cnt_reg.sv
// rtl/cnt_reg.sv - WIDTH-bit register with synchronous reset and write enable
//
// Purpose : holds the binary count.
// Ports   : clk, rst (sync, active-high), we (write enable), d (next value),
//           q (registered value).
module cnt_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mod_n_cnt.sv
// rtl/mod_n_cnt.sv - up/down modulo-N counter with clear, load and Gray output
//
// Purpose : counts 0..MOD-1 in either direction with wrap-around; priority per
//           edge is rst > clr > load > en.
// Ports   : clk, rst (sync, active-high)
//           bus.en / bus.up_dn   count enable and direction (1 = up)
//           bus.clr              synchronous clear
//           bus.load / load_val  parallel load; out-of-range values rejected
//           bus.cnt / cnt_gray   registered binary and Gray count
//           bus.tc               combinational terminal count
//           bus.wrap / load_err  registered one-cycle pulses
module mod_n_cnt
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic         clk,
  input  logic         rst,
  mod_n_cnt_if.slave   bus
);

  if (!mod_is_legal(WIDTH, MOD)) begin : g_bad_mod
    $error("mod_n_cnt: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  cnt_op_e          op;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_we;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             wrap_q;
  logic             err_d;
  logic             err_q;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (cnt_q == MAX);
  assign at_zero = (cnt_q == '0);

  // Cascade output: deliberately blind to clr/load so a chained stage sees a
  // stable enable that depends only on this stage's count and direction.
  assign bus.tc = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

  always_comb begin
    op = OP_HOLD;
    if (bus.clr) begin
      op = OP_CLR;
    end else if (bus.load) begin
      op = (bus.load_val <= MAX) ? OP_LOAD : OP_REJECT;
    end else if (bus.en) begin
      op = bus.up_dn ? OP_UP : OP_DN;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    cnt_we = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    case (op)
      OP_CLR: begin
        cnt_d  = '0;
        cnt_we = 1'b1;
      end
      OP_LOAD: begin
        cnt_d  = bus.load_val;
        cnt_we = 1'b1;
      end
      OP_REJECT: begin
        err_d = 1'b1;
      end
      OP_UP: begin
        // When MOD == 2**WIDTH the explicit wrap equals natural overflow.
        cnt_d  = at_max ? '0 : cnt_q + WIDTH'(1);
        cnt_we = 1'b1;
        wrap_d = at_max;
      end
      OP_DN: begin
        cnt_d  = at_zero ? MAX : cnt_q - WIDTH'(1);
        cnt_we = 1'b1;
        wrap_d = at_zero;
      end
      default: begin
        cnt_d  = cnt_q;
        cnt_we = 1'b0;
      end
    endcase
  end

  // Gray is encoded from the next-state value so it lands on the same edge
  // as the binary count instead of trailing it by a cycle.
  assign gray_d = WIDTH'(bin2gray(32'(cnt_d)));

  cnt_reg #(
    .WIDTH (WIDTH)
  ) u_cnt_reg (
    .clk (clk),
    .rst (rst),
    .we  (cnt_we),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (cnt_we) begin
        gray_q <= gray_d;
      end
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.cnt_gray = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_mod_n_cnt.sv
// tb/tb_mod_n_cnt.sv - self-checking bench for mod_n_cnt (MOD 10/4 and MOD 4/2)
module tb_mod_n_cnt;

  localparam int W_A   = 4;
  localparam int MOD_A = 10;
  localparam int W_B   = 2;
  localparam int MOD_B = 4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  mod_n_cnt_if #(.WIDTH(W_A)) bus_a ();
  mod_n_cnt_if #(.WIDTH(W_B)) bus_b ();

  mod_n_cnt #(.WIDTH(W_A), .MOD(MOD_A)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  mod_n_cnt #(.WIDTH(W_B), .MOD(MOD_B)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  // Reference state: count as a plain integer plus the two expected pulses.
  int ma_cnt, ma_wrap, ma_err;
  int mb_cnt, mb_wrap, mb_err;
  int b_wraps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit exp_tc(input int modv, input int c, input bit en, input bit up);
    return en && ((up && c == modv - 1) || (!up && c == 0));
  endfunction

  task automatic model_step(input int modv, inout int c, inout int w, inout int e,
                            input bit r, input bit en, input bit up, input bit cl,
                            input bit ld, input int lv);
    w = 0;
    e = 0;
    if (r || cl) begin
      c = 0;
    end else if (ld) begin
      if (lv < modv) c = lv;
      else e = 1;
    end else if (en) begin
      if (up) begin
        w = (c == modv - 1);
        c = (c + 1) % modv;
      end else begin
        w = (c == 0);
        c = (c + modv - 1) % modv;
      end
    end
  endtask

  task automatic cyc_a(input bit r, input bit en, input bit up, input bit cl,
                       input bit ld, input int lv, input string tag);
    rst_a          = r;
    bus_a.en       = en;
    bus_a.up_dn    = up;
    bus_a.clr      = cl;
    bus_a.load     = ld;
    bus_a.load_val = W_A'(lv);
    #1;
    chk({tag, ".tc"}, 32'(bus_a.tc), 32'(exp_tc(MOD_A, ma_cnt, en, up)));
    @(posedge clk);
    #1;
    model_step(MOD_A, ma_cnt, ma_wrap, ma_err, r, en, up, cl, ld, lv);
    chk({tag, ".cnt"},      32'(bus_a.cnt),      ma_cnt);
    chk({tag, ".gray"},     32'(bus_a.cnt_gray), gray(ma_cnt));
    chk({tag, ".wrap"},     32'(bus_a.wrap),     ma_wrap);
    chk({tag, ".load_err"}, 32'(bus_a.load_err), ma_err);
  endtask

  task automatic cyc_b(input bit r, input bit en, input bit up, input bit cl,
                       input bit ld, input int lv, input string tag);
    rst_b          = r;
    bus_b.en       = en;
    bus_b.up_dn    = up;
    bus_b.clr      = cl;
    bus_b.load     = ld;
    bus_b.load_val = W_B'(lv);
    #1;
    chk({tag, ".tc"}, 32'(bus_b.tc), 32'(exp_tc(MOD_B, mb_cnt, en, up)));
    @(posedge clk);
    #1;
    model_step(MOD_B, mb_cnt, mb_wrap, mb_err, r, en, up, cl, ld, lv);
    if (mb_wrap != 0) b_wraps++;
    chk({tag, ".cnt"},      32'(bus_b.cnt),      mb_cnt);
    chk({tag, ".gray"},     32'(bus_b.cnt_gray), gray(mb_cnt));
    chk({tag, ".wrap"},     32'(bus_b.wrap),     mb_wrap);
    chk({tag, ".load_err"}, 32'(bus_b.load_err), mb_err);
  endtask

  initial begin
    int exp_b_cnt[5];
    int exp_b_gray[5];
    exp_b_cnt  = '{1, 2, 3, 0, 1};
    exp_b_gray = '{1, 3, 2, 0, 1};

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.en = 1'b0; bus_a.up_dn = 1'b1; bus_a.clr = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
    bus_b.en = 1'b0; bus_b.up_dn = 1'b1; bus_b.clr = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0;
    @(posedge clk);
    #1;
    ma_cnt = 0; ma_wrap = 0; ma_err = 0;
    mb_cnt = 0; mb_wrap = 0; mb_err = 0;
    b_wraps = 0;
    rst_b = 1'b0;

    // Reset for two cycles, then count up through the 9 -> 0 wrap.
    cyc_a(1, 0, 1, 0, 0, 0, "r035.rst");
    cyc_a(1, 0, 1, 0, 0, 0, "r035.rst");
    for (int i = 0; i < 12; i++) cyc_a(0, 1, 1, 0, 0, 0, "r035.up");
    chk("r035.end_cnt", 32'(bus_a.cnt), 2);

    // Down from 0 wraps to 9.
    cyc_a(0, 0, 1, 1, 0, 0, "r036.clr");
    for (int i = 0; i < 3; i++) cyc_a(0, 1, 0, 0, 0, 0, "r036.dn");
    chk("r036.end_cnt", 32'(bus_a.cnt), 7);

    // Legal load, then an out-of-range load that must hold the count.
    cyc_a(0, 0, 1, 0, 1, 7, "r037.load7");
    chk("r037.gray_const", 32'(bus_a.cnt_gray), 4);
    cyc_a(0, 1, 1, 0, 1, 12, "r037.load12");
    chk("r037.err_const", 32'(bus_a.load_err), 1);
    cyc_a(0, 0, 1, 0, 0, 0, "r037.hold");
    cyc_a(0, 0, 1, 0, 1, 15, "r037.load15");
    cyc_a(0, 0, 0, 0, 1, 10, "r037.load10");

    // clr and load together at terminal count: clr wins, no wrap.
    cyc_a(0, 0, 1, 0, 1, 9, "r038.load9");
    cyc_a(0, 1, 1, 1, 1, 3, "r038.clr_load");
    chk("r038.cnt_const", 32'(bus_a.cnt), 0);
    chk("r038.wrap_const", 32'(bus_a.wrap), 0);
    // load at terminal count also suppresses wrap.
    cyc_a(0, 1, 0, 0, 1, 4, "r024.load_at_tc");

    // Reset mid-count, then resume; tc during reset follows count 0.
    cyc_a(0, 1, 1, 0, 0, 0, "r039.up");
    cyc_a(1, 1, 1, 0, 0, 0, "r039.rst");
    cyc_a(0, 1, 1, 0, 0, 0, "r039.resume");
    cyc_a(0, 1, 1, 0, 0, 0, "r039.resume");
    chk("r039.cnt_const", 32'(bus_a.cnt), 2);
    cyc_a(1, 1, 0, 0, 0, 0, "r030.rst_dn");
    cyc_a(1, 1, 0, 0, 0, 0, "r030.rst_dn");

    // Immediate direction reversal and holding with en=0.
    cyc_a(0, 1, 1, 0, 0, 0, "r025.up");
    cyc_a(0, 1, 0, 0, 0, 0, "r025.dn");
    cyc_a(0, 1, 0, 0, 0, 0, "r025.dn");
    cyc_a(0, 0, 0, 0, 0, 0, "r021.hold");
    cyc_a(0, 0, 1, 0, 0, 0, "r021.hold");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc_a(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)), "rnd_a");
    end

    // Full-range modulus: wrap by natural overflow.
    for (int i = 0; i < 5; i++) begin
      cyc_b(0, 1, 1, 0, 0, 0, "r040.up");
      chk("r040.cnt_const",  32'(bus_b.cnt),      exp_b_cnt[i]);
      chk("r040.gray_const", 32'(bus_b.cnt_gray), exp_b_gray[i]);
    end
    chk("r040.wrap_count", b_wraps, 1);
    for (int i = 0; i < 150; i++) begin
      cyc_b(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), "rnd_b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_n_cnt.md
MOD_N_CNT -- requirements
Module: mod_n_cnt

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 Parameter MOD, default 10, count modulus; legal range 2 <= MOD <= 2**WIDTH.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up_dn  input  1  direction select: 1 = up, 0 = down.
REQ-007 Port clr  input  1  synchronous clear to 0.
REQ-008 Port load  input  1  synchronous parallel-load strobe.
REQ-009 Port load_val  input  WIDTH  value presented with load.
REQ-010 Port cnt  output  WIDTH  registered binary count.
REQ-011 Port cnt_gray  output  WIDTH  registered Gray encoding of the next-state count, aligned with cnt.
REQ-012 Port tc  output  1  combinational terminal count, for cascading.
REQ-013 Port wrap  output  1  registered one-cycle wrap pulse.
REQ-014 Port load_err  output  1  registered one-cycle pulse flagging an out-of-range load.

Function
REQ-015 Per-edge priority SHALL be: rst > clr > load > en; lower-priority inputs are ignored in that cycle.
REQ-016 clr=1 SHALL set cnt=0 and cnt_gray=0, and SHALL hold wrap=0 and load_err=0 for the following cycle.
REQ-017 When load=1 and load_val <= MOD-1, the block SHALL set cnt=load_val and cnt_gray=load_val^(load_val>>1).
REQ-018 When load=1 and load_val >= MOD, cnt SHALL hold its value and load_err SHALL be 1 for exactly the next cycle.
REQ-019 With en=1 and up_dn=1, cnt SHALL increment by 1, except cnt==MOD-1, which SHALL go to 0.
REQ-020 With en=1 and up_dn=0, cnt SHALL decrement by 1, except cnt==0, which SHALL go to MOD-1.
REQ-021 With en=0 and no clr/load, cnt, cnt_gray SHALL hold.
REQ-022 tc SHALL equal en & ((up_dn & cnt==MOD-1) | (~up_dn & cnt==0)), independent of clr/load.
REQ-023 wrap SHALL be 1 for exactly the cycle after any edge where the count wrapped per REQ-019/020, else 0.
REQ-024 A load or clr in the same cycle as tc=1 SHALL suppress wrap.
REQ-025 Direction change SHALL take effect on the same edge; no dead cycle.
REQ-026 When MOD == 2**WIDTH, wrap-around SHALL occur by natural overflow with identical outputs.
REQ-027 cnt SHALL never hold a value >= MOD after any edge.

Reset
REQ-028 rst=1 at an edge SHALL set cnt=0, cnt_gray=0, wrap=0, load_err=0, overriding all inputs.
REQ-029 rst asserted mid-count SHALL abandon the count; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-030 tc during rst SHALL follow REQ-022 from the reset value (cnt=0).

Structure
REQ-031 Shared package cnt_pkg SHALL hold the bin2gray function and the legal-MOD check.
REQ-032 A parameter outside the legal MOD range SHALL be an elaboration-time error.
REQ-033 One sub-module, cnt_reg (WIDTH-bit synchronous-reset register with enable), SHALL hold cnt.
REQ-034 Next-state, tc, wrap and load_err logic SHALL reside in mod_n_cnt.

Verification (WIDTH=4, MOD=10)
REQ-035 rst=1 for 2 cycles, then en=1, up_dn=1 for 12 cycles -> cnt 0,1..9,0,1; wrap=1 only the cycle after 9->0; tc=1 only while cnt=9.
REQ-036 cnt=0, en=1, up_dn=0 for 3 cycles -> cnt 9,8,7; wrap=1 the cycle after 0->9.
REQ-037 load=1, load_val=7 -> cnt=7, cnt_gray=4'b0100; then load_val=12 -> cnt holds 7, load_err=1 one cycle.
REQ-038 cnt=9, en=1, up_dn=1, clr=1 and load=1 (load_val=3) together -> cnt=0, wrap=0, load_err=0.
REQ-039 Counting up at cnt=5, rst=1 one cycle -> cnt=0 next edge, then 1,2 with en=1.
REQ-040 WIDTH=2, MOD=4, up 5 cycles from 0 -> cnt 1,2,3,0,1; cnt_gray 01,11,10,00,01; wrap once.
